// File: rtl/core_ctrl_seq.sv
// rtl/core_ctrl_seq.sv - autonomous instruction/SRAM sequencer for the systolic core
// Optional readout phase enabled by defining CORE_CTRL_SEQ_READOUT_EN.
module core_ctrl_seq #(
    parameter int col      = 8,
    parameter int len_nij  = 16,
    parameter int num_kij  = 9,
    parameter int addr_w   = 11,
    parameter int wgt_base = 1024,
    parameter int act_base = 0,
    parameter int gap      = 5,
    parameter int drain    = 20,
    parameter int flush    = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [6:0]        inst,
    output logic              cen_act_wgt,
    output logic              wen_act_wgt,
    output logic [addr_w-1:0] addr_act_wgt,
    output logic [3:0]        kij_idx,
    output logic              busy,
    output logic              done
);
    typedef enum logic [3:0] {IDLE, WL0, G1, WLD, DRN, AL0, G2, EXE, FLS, RDO, FIN} state_t;

    state_t            state;
    logic [15:0]       cnt;
    logic [3:0]        kij;
    int                phase_len;
    logic              last;
    logic [6:0]        inst_d;
    logic              cen_d;
    logic [addr_w-1:0] addr_d;

    always_comb begin
        phase_len = 1;
        case (state)
            WL0:      phase_len = col + 1;
            G1, G2:   phase_len = gap;
            WLD:      phase_len = col;
            DRN:      phase_len = drain;
            AL0:      phase_len = len_nij + 1;
            EXE, RDO: phase_len = len_nij;
            FLS:      phase_len = flush;
            default:  phase_len = 1;
        endcase
    end

    assign last = (int'(cnt) >= phase_len - 1);

    // Outputs are decoded from the current phase position and registered,
    // so they trail the state register by one cycle.
    always_comb begin
        inst_d = '0;
        cen_d  = 1'b1;
        addr_d = '0;
        case (state)
            WL0: begin
                if (int'(cnt) < col) begin
                    cen_d  = 1'b0;
                    addr_d = addr_w'(wgt_base + int'(kij) * col + int'(cnt));
                end
                inst_d[2] = (cnt != 16'd0);
            end
            WLD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            AL0: begin
                if (int'(cnt) < len_nij) begin
                    cen_d  = 1'b0;
                    addr_d = addr_w'(act_base + int'(cnt));
                end
                inst_d[2] = (cnt != 16'd0);
            end
            EXE: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
`ifdef CORE_CTRL_SEQ_READOUT_EN
            RDO: inst_d[4] = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            kij          <= '0;
            inst         <= '0;
            cen_act_wgt  <= 1'b1;
            wen_act_wgt  <= 1'b1;
            addr_act_wgt <= '0;
            kij_idx      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            inst         <= inst_d;
            cen_act_wgt  <= cen_d;
            wen_act_wgt  <= 1'b1;
            addr_act_wgt <= addr_d;
            kij_idx      <= kij;
            busy         <= (state != IDLE);
            done         <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WL0;
                        cnt   <= '0;
                        kij   <= '0;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    cnt   <= '0;
                    kij   <= '0;
                end
                default: begin
                    if (last) begin
                        cnt <= '0;
                        case (state)
                            WL0: state <= G1;
                            G1:  state <= WLD;
                            WLD: state <= DRN;
                            DRN: state <= AL0;
                            AL0: state <= G2;
                            G2:  state <= EXE;
                            EXE: state <= FLS;
                            FLS: begin
                                if (int'(kij) < num_kij - 1) begin
                                    kij   <= kij + 4'd1;
                                    state <= WL0;
                                end else begin
`ifdef CORE_CTRL_SEQ_READOUT_EN
                                    state <= RDO;
`else
                                    state <= FIN;
`endif
                                end
                            end
`ifdef CORE_CTRL_SEQ_READOUT_EN
                            RDO: state <= FIN;
`endif
                            default: state <= IDLE;
                        endcase
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_ctrl_seq.sv
// tb/tb_core_ctrl_seq.sv - directed bench for core_ctrl_seq (single and nine kij passes)
module tb_core_ctrl_seq;
`ifdef CORE_CTRL_SEQ_READOUT_EN
    localparam int RDO_LEN = 16;
    localparam int EXP_FIRST_FRD = 181;
`else
    localparam int RDO_LEN = 0;
    localparam int EXP_FIRST_FRD = 0;
`endif
    localparam int EXP_DONE_ONE  = 181 + RDO_LEN;
    localparam int EXP_DONE_FULL = 9 * 180 + 1 + RDO_LEN;

    logic        clk = 1'b0;
    logic        reset_one, start_one, reset_full, start_full;
    logic [6:0]  one_inst, full_inst;
    logic        one_cen, one_wen, full_cen, full_wen;
    logic [10:0] one_addr, full_addr;
    logic [3:0]  one_kij, full_kij;
    logic        one_busy, one_done, full_busy, full_done;

    int vectors = 0;
    int miscompares = 0;
    int inv_bad = 0;

    always #5 clk = ~clk;

    core_ctrl_seq #(.num_kij(1)) u_one (
        .clk(clk), .reset(reset_one), .start(start_one), .inst(one_inst),
        .cen_act_wgt(one_cen), .wen_act_wgt(one_wen), .addr_act_wgt(one_addr),
        .kij_idx(one_kij), .busy(one_busy), .done(one_done)
    );

    core_ctrl_seq #(.num_kij(9)) u_full (
        .clk(clk), .reset(reset_full), .start(start_full), .inst(full_inst),
        .cen_act_wgt(full_cen), .wen_act_wgt(full_wen), .addr_act_wgt(full_addr),
        .kij_idx(full_kij), .busy(full_busy), .done(full_done)
    );

    // Protocol invariants watched on both instances every cycle after reset.
    always @(negedge clk) begin
        if (!reset_one && !reset_full) begin
            if (one_wen !== 1'b1 || full_wen !== 1'b1) inv_bad++;
            if ((one_inst[0] && one_inst[1]) || (full_inst[0] && full_inst[1])) inv_bad++;
            if ((one_inst[2] && one_inst[3]) || (full_inst[2] && full_inst[3])) inv_bad++;
            if (one_inst[6:5] !== 2'b00 || full_inst[6:5] !== 2'b00) inv_bad++;
`ifndef CORE_CTRL_SEQ_READOUT_EN
            if (one_inst[4] || full_inst[4]) inv_bad++;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_one(input string tag);
        int wcnt = 0, wbad = 0, acnt = 0, abad = 0, nwr = 0;
        int nload = 0, first_load = 0, nexe = 0, first_exe = 0;
        int ndone = 0, done_cyc = 0, nfrd = 0, first_frd = 0;
        logic [11:0] wr_mask = '0;
        @(negedge clk);
        start_one = 1'b1;
        @(negedge clk);
        start_one = 1'b0;
        check({tag, " busy_before_latency"}, 32'(one_busy), 32'd0);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, " busy_rise"}, 32'(one_busy), 32'd1);
            if (!one_cen && c <= 9) begin
                wcnt++;
                if (one_addr !== 11'(1024 + c - 1)) wbad++;
            end
            if (!one_cen && c >= 43 && c <= 58) begin
                acnt++;
                if (one_addr !== 11'(c - 43)) abad++;
            end
            if (c <= 11 && one_inst[2]) wr_mask[c] = 1'b1;
            if (one_inst[2]) nwr++;
            if (one_inst[0]) begin nload++; if (first_load == 0) first_load = c; end
            if (one_inst[1]) begin nexe++; if (first_exe == 0) first_exe = c; end
            if (one_inst[4]) begin nfrd++; if (first_frd == 0) first_frd = c; end
            if (one_done) begin ndone++; done_cyc = c; end
        end
        check({tag, " wgt_addr_count"}, 32'(wcnt), 32'd8);
        check({tag, " wgt_addr_bad"}, 32'(wbad), 32'd0);
        check({tag, " l0_wr_after_addr"}, 32'(wr_mask), 32'h3FC);
        check({tag, " act_addr_count"}, 32'(acnt), 32'd16);
        check({tag, " act_addr_bad"}, 32'(abad), 32'd0);
        check({tag, " l0_wr_total"}, 32'(nwr), 32'd24);
        check({tag, " load_count"}, 32'(nload), 32'd8);
        check({tag, " first_load"}, 32'(first_load), 32'd15);
        check({tag, " exec_count"}, 32'(nexe), 32'd16);
        check({tag, " first_exec"}, 32'(first_exe), 32'd65);
        check({tag, " frd_count"}, 32'(nfrd), 32'(RDO_LEN));
        check({tag, " first_frd"}, 32'(first_frd), 32'(EXP_FIRST_FRD));
        check({tag, " done_count"}, 32'(ndone), 32'd1);
        check({tag, " done_cycle"}, 32'(done_cyc), 32'(EXP_DONE_ONE));
        check({tag, " busy_end"}, 32'(one_busy), 32'd0);
        check({tag, " kij_end"}, 32'(one_kij), 32'd0);
    endtask

    initial begin
        int wcnt = 0, wbad = 0, acnt = 0, abad = 0, kij_bad = 0, ndone = 0, done_cyc = 0;
        logic [8:0] kij_seen = '0;
        logic [3:0] prev_k = '0;

        reset_one = 1'b1; reset_full = 1'b1; start_one = 1'b0; start_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst inst", 32'(one_inst), 32'd0);
        check("rst cen", 32'(one_cen), 32'd1);
        check("rst wen", 32'(one_wen), 32'd1);
        check("rst addr", 32'(one_addr), 32'd0);
        check("rst kij", 32'(one_kij), 32'd0);
        check("rst busy", 32'(one_busy), 32'd0);
        check("rst done", 32'(one_done), 32'd0);
        reset_one = 1'b0; reset_full = 1'b0;

        run_one("single");

        // Nine-kij pass with a stray start pulse during the first EXE phase.
        @(negedge clk);
        start_full = 1'b1;
        @(negedge clk);
        start_full = 1'b0;
        for (int c = 1; c <= 1645; c++) begin
            @(negedge clk);
            start_full = (c == 70);
            if (!full_cen && full_addr >= 11'd1024) begin
                if (full_addr !== 11'(1024 + wcnt)) wbad++;
                wcnt++;
            end
            if (!full_cen && full_addr < 11'd1024) begin
                if (full_addr !== 11'(acnt % 16)) abad++;
                acnt++;
            end
            if (full_busy && full_kij <= 4'd8) kij_seen[full_kij] = 1'b1;
            if (full_busy && full_kij > 4'd8) kij_bad++;
            if (full_kij != prev_k && full_kij != prev_k + 4'd1 && full_kij != 4'd0) kij_bad++;
            prev_k = full_kij;
            if (full_done) begin ndone++; done_cyc = c; end
        end
        start_full = 1'b0;
        check("full wgt_addr_count", 32'(wcnt), 32'd72);
        check("full wgt_addr_bad", 32'(wbad), 32'd0);
        check("full act_addr_count", 32'(acnt), 32'd144);
        check("full act_addr_bad", 32'(abad), 32'd0);
        check("full kij_seen", 32'(kij_seen), 32'h1FF);
        check("full kij_bad", 32'(kij_bad), 32'd0);
        check("full done_count", 32'(ndone), 32'd1);
        check("full done_cycle", 32'(done_cyc), 32'(EXP_DONE_FULL));
        check("full busy_end", 32'(full_busy), 32'd0);
        check("full kij_end", 32'(full_kij), 32'd0);

        // Reset in the middle of EXE, then a fresh full pass.
        @(negedge clk);
        start_one = 1'b1;
        @(negedge clk);
        start_one = 1'b0;
        repeat (70) @(negedge clk);
        check("mid exec_active", 32'(one_inst), 32'h0A);
        reset_one = 1'b1;
        @(negedge clk);
        check("mid_rst inst", 32'(one_inst), 32'd0);
        check("mid_rst cen", 32'(one_cen), 32'd1);
        check("mid_rst busy", 32'(one_busy), 32'd0);
        check("mid_rst kij", 32'(one_kij), 32'd0);
        reset_one = 1'b0;
        run_one("after_reset");

        check("invariants", 32'(inv_bad), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
